key_filter: RTL

KEY_FILTER -- requirements
Module: key_filter

---
 rtl/key_filter.sv | 199 +++++++++++++++++++
 1 files changed

// File: rtl/key_filter.sv
// ---------------------------------------------------------------------------
// key_filter
//
// Debounces N_KEYS independent push-button inputs. Each raw level passes
// through a two-flop synchronizer, then a per-channel four-state FSM accepts
// a new level only after it has been seen stable for a full debounce window.
// Clean one-cycle press/release pulses are generated alongside the level.
//
// Optional feature (compile-time macro KEY_FILTER_LONGPRESS_EN):
//   adds a per-channel hold counter and a one-shot long-press pulse.
//   Without the macro key_long is tied to 0 and no hold logic exists.
//
// Parameters:
//   N_KEYS   - number of button channels (1..8)
//   DB_CNT   - debounce stability window in clk cycles (>= 1)
//   LONG_CNT - hold time after key_press before key_long fires (>= 1)
//
// Ports:
//   clk         - system clock, rising edge
//   rst_n       - asynchronous active-low reset
//   key_in      - raw button levels, 1 = pressed, asynchronous to clk
//   key_level   - debounced button level
//   key_press   - one-cycle pulse on a debounced 0->1 transition
//   key_release - one-cycle pulse on a debounced 1->0 transition
//   key_long    - one-cycle pulse once a key has been held LONG_CNT cycles
// ---------------------------------------------------------------------------
module key_filter #(
   parameter int N_KEYS   = 3,
   parameter int DB_CNT   = 1000000,
   parameter int LONG_CNT = 50000000
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [N_KEYS-1:0] key_in,
   output logic [N_KEYS-1:0] key_level,
   output logic [N_KEYS-1:0] key_press,
   output logic [N_KEYS-1:0] key_release,
   output logic [N_KEYS-1:0] key_long
);

   localparam int DbW = $clog2(DB_CNT + 1);
   localparam logic [DbW-1:0] DbLast = DbW'(DB_CNT - 1);

   typedef enum logic [1:0] {
      IDLE       = 2'd0,
      PRESS_DB   = 2'd1,
      HELD       = 2'd2,
      RELEASE_DB = 2'd3
   } state_e;

   // Catch out-of-range configurations at elaboration time.
   if (N_KEYS < 1 || N_KEYS > 8) begin : gBadKeys
      $error("key_filter: N_KEYS must be in 1..8");
   end
   if (DB_CNT < 1) begin : gBadDb
      $error("key_filter: DB_CNT must be at least 1");
   end
   if (LONG_CNT < 1) begin : gBadLong
      $error("key_filter: LONG_CNT must be at least 1");
   end

   logic [N_KEYS-1:0] syncMeta_q;
   logic [N_KEYS-1:0] syncOut_q;

   // Two-flop synchronizer for every raw key line; syncOut_q is the only
   // copy of the key that the FSMs are allowed to look at.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         syncMeta_q <= '0;
         syncOut_q  <= '0;
      end else begin
         syncMeta_q <= key_in;
         syncOut_q  <= syncMeta_q;
      end
   end

   for (genvar g = 0; g < N_KEYS; g++) begin : gChan
      state_e          state_q, state_d;
      logic [DbW-1:0]  dbCnt_q, dbCnt_d;
      logic            press_q, press_d;
      logic            release_q, release_d;
      logic            s;

      assign s = syncOut_q[g];

      // Per-channel state, debounce counter and registered edge pulses.
      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            state_q   <= IDLE;
            dbCnt_q   <= '0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
         end else begin
            state_q   <= state_d;
            dbCnt_q   <= dbCnt_d;
            press_q   <= press_d;
            release_q <= release_d;
         end
      end

      // Next-state logic. Any sample that disagrees with the candidate level
      // drops back to the settled state, so a glitch shorter than the
      // window never reaches key_level. The counter stops at DbLast because
      // the FSM always leaves the debounce state on that compare.
      always_comb begin
         state_d   = state_q;
         dbCnt_d   = dbCnt_q;
         press_d   = 1'b0;
         release_d = 1'b0;
         case (state_q)
            IDLE: begin
               if (s) begin
                  state_d = PRESS_DB;
                  dbCnt_d = '0;
               end
            end
            PRESS_DB: begin
               if (!s) begin
                  state_d = IDLE;
                  dbCnt_d = '0;
               end else if (dbCnt_q == DbLast) begin
                  state_d = HELD;
                  press_d = 1'b1;
               end else begin
                  dbCnt_d = dbCnt_q + 1'b1;
               end
            end
            HELD: begin
               if (!s) begin
                  state_d = RELEASE_DB;
                  dbCnt_d = '0;
               end
            end
            RELEASE_DB: begin
               if (s) begin
                  state_d = HELD;
                  dbCnt_d = '0;
               end else if (dbCnt_q == DbLast) begin
                  state_d   = IDLE;
                  release_d = 1'b1;
               end else begin
                  dbCnt_d = dbCnt_q + 1'b1;
               end
            end
            default: begin
               state_d = IDLE;
               dbCnt_d = '0;
            end
         endcase
      end

      assign key_level[g]   = (state_q == HELD) || (state_q == RELEASE_DB);
      assign key_press[g]   = press_q;
      assign key_release[g] = release_q;

`ifdef KEY_FILTER_LONGPRESS_EN
      localparam int LongW = $clog2(LONG_CNT + 1);
      localparam logic [LongW-1:0] LongLast = LongW'(LONG_CNT - 1);
      localparam logic [LongW-1:0] LongMax  = LongW'(LONG_CNT);

      logic [LongW-1:0] holdCnt_q, holdCnt_d;
      logic             long_q, long_d;

      // Hold counter and one-shot long-press pulse register.
      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            holdCnt_q <= '0;
            long_q    <= 1'b0;
         end else begin
            holdCnt_q <= holdCnt_d;
            long_q    <= long_d;
         end
      end

      // The count restarts only on a genuine new press, so a short release
      // glitch cannot re-arm the long pulse. It parks at LONG_CNT, one past
      // the firing value, which is what keeps the pulse from repeating.
      always_comb begin
         holdCnt_d = holdCnt_q;
         long_d    = 1'b0;
         if (press_d) begin
            holdCnt_d = '0;
         end else if (key_level[g]) begin
            if (holdCnt_q == LongLast) begin
               long_d = 1'b1;
            end
            if (holdCnt_q != LongMax) begin
               holdCnt_d = holdCnt_q + 1'b1;
            end
         end
      end

      assign key_long[g] = long_q;
`else
      assign key_long[g] = 1'b0;
`endif
   end

endmodule
